div_unit: RTL and testbench

Iterative radix-2 divider for the RV32M division instructions (DIV, DIVU, REM, REMU). It sits in the execute stage beside the combinational ALU and is fed from the same operand bus and 5-bit operation code. Its result is selected into the same writeback path as the ALU result. It takes the long-latency division off the ALU's single-cycle path, and uses a start/busy/done handshake so the pipeline control can stall while it runs.

---
 rtl/div_pkg.sv | 24 ++
 rtl/div_step.sv | 23 ++
 rtl/div_unit.sv | 121 ++++++++++++
 tb/tb_div_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and types for the RV32M iterative divider.
// OP codes match the ALU decoder so both units decode one bus.
package div_pkg;

  localparam logic [4:0] OP_DIV  = 5'd14;
  localparam logic [4:0] OP_DIVU = 5'd15;
  localparam logic [4:0] OP_REM  = 5'd16;
  localparam logic [4:0] OP_REMU = 5'd17;

  localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } state_t;

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_DIVU) ||
           (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in a dividend bit,
// trial-subtract the divisor, keep or restore.
module div_step
  import div_pkg::*;
(
  input  logic [32:0] rem,
  input  logic [31:0] div,
  input  logic        din,
  output logic [32:0] rem_nx,
  output logic        q
);

  logic [33:0] sh;
  logic [32:0] diff;

  always_comb begin
    sh     = {rem, din};
    diff   = sh[32:0] - {1'b0, div};
    q      = (sh >= {2'b00, div});
    rem_nx = q ? diff : sh[32:0];
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 divider for DIV/DIVU/REM/REMU.
// Start/busy/done handshake; 33-cycle latency, 1 cycle for special cases.
module div_unit
  import div_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        ABORT,
  input  logic [4:0]  OP,
  input  logic [31:0] X,
  input  logic [31:0] Y,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RESULT
);

  state_t      state, state_nx;
  logic [5:0]  cnt;
  logic [32:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic [4:0]  op_q;
  logic        sx, sy, special;

  logic        signed_op, is_rem, x_neg, y_neg;
  logic        y_zero, ovf, accept;
  logic [31:0] x_mag, y_mag, spec_res;
  logic [32:0] step_rem;
  logic        step_q;
  logic [31:0] q_fix, r_fix, fin;

  always_comb begin
    signed_op = (OP == OP_DIV) || (OP == OP_REM);
    is_rem    = (OP == OP_REM) || (OP == OP_REMU);
    x_neg     = signed_op && X[31];
    y_neg     = signed_op && Y[31];
    x_mag     = x_neg ? -X : X;
    y_mag     = y_neg ? -Y : Y;
    y_zero    = (Y == 32'd0);
    ovf       = signed_op && (X == INT_MIN) && (Y == DIV0_Q);
    accept    = (state == IDLE) && START && !ABORT && is_div_op(OP);
    if (y_zero)
      spec_res = is_rem ? X : DIV0_Q;
    else
      spec_res = is_rem ? 32'd0 : INT_MIN;
  end

  div_step u_step (
    .rem    (rem),
    .div    (dvs),
    .din    (quo[31]),
    .rem_nx (step_rem),
    .q      (step_q)
  );

  // Quotient sign follows both operands; remainder follows the dividend.
  always_comb begin
    q_fix = ((op_q == OP_DIV) && (sx ^ sy)) ? -quo : quo;
    r_fix = ((op_q == OP_REM) && sx) ? -rem[31:0] : rem[31:0];
    if (special)
      fin = quo;
    else if ((op_q == OP_REM) || (op_q == OP_REMU))
      fin = r_fix;
    else
      fin = q_fix;
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (accept) state_nx = (y_zero || ovf) ? FINISH : CALC;
      CALC:   if (cnt == 6'd0) state_nx = FINISH;
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (ABORT) state_nx = IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt     <= 6'd0;
      rem     <= 33'd0;
      quo     <= 32'd0;
      dvs     <= 32'd0;
      op_q    <= 5'd0;
      sx      <= 1'b0;
      sy      <= 1'b0;
      special <= 1'b0;
      RESULT  <= 32'd0;
      DONE    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (accept) begin
        op_q    <= OP;
        sx      <= x_neg;
        sy      <= y_neg;
        dvs     <= y_mag;
        cnt     <= 6'd31;
        rem     <= 33'd0;
        special <= y_zero || ovf;
        quo     <= (y_zero || ovf) ? spec_res : x_mag;
      end else if ((state == CALC) && !ABORT) begin
        rem <= step_rem;
        quo <= {quo[30:0], step_q};
        cnt <= cnt - 6'd1;
      end else if ((state == FINISH) && !ABORT) begin
        RESULT <= fin;
        DONE   <= 1'b1;
      end
    end
  end

  assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table plus
// abort, reset, illegal-op and held-START sequences.
module tb_div_unit;
  import div_pkg::*;

  logic        CLK = 1'b0;
  logic        RST, START, ABORT;
  logic [4:0]  OP;
  logic [31:0] X, Y;
  logic        BUSY, DONE;
  logic [31:0] RESULT;

  always #5 CLK = ~CLK;

  div_unit dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .ABORT  (ABORT),
    .OP     (OP),
    .X      (X),
    .Y      (Y),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .RESULT (RESULT)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    int          lat;
    int          t0;
  } exp_t;

  localparam int NV = 15;

  vec_t        tbl [NV];
  exp_t        sb [$];
  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  int          dones  = 0;
  int          d0;
  logic [31:0] last;

  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (DONE === 1'b1) begin
      dones++;
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got DONE=1 expected no DONE");
      end else begin
        e = sb.pop_front();
        chk("result", RESULT, e.exp);
        chk("latency", 32'(cyc - e.t0), 32'(e.lat));
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge CLK);
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL timeout: got no DONE expected DONE within 60 cycles");
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [4:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp,
                        input int lat);
    exp_t e;
    @(negedge CLK);
    START = 1'b1; OP = op; X = x; Y = y;
    @(posedge CLK);
    #1;
    START = 1'b0;
    e.exp = exp; e.lat = lat; e.t0 = cyc;
    sb.push_back(e);
    @(negedge CLK);
    chk("busy_after_start", 32'(BUSY), 32'd1);
    wait_idle();
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    RST = 1'b1; START = 1'b0; ABORT = 1'b0;
    OP = 5'd0; X = 32'd0; Y = 32'd0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_busy", 32'(BUSY), 32'd0);
    chk("reset_done", 32'(DONE), 32'd0);
    chk("reset_result", RESULT, 32'd0);
    RST = 1'b0;

    tbl[0]  = '{OP_DIVU, 32'd100, 32'd7, 32'd14, 33};
    tbl[1]  = '{OP_REMU, 32'd100, 32'd7, 32'd2, 33};
    tbl[2]  = '{OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33};
    tbl[3]  = '{OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33};
    tbl[4]  = '{OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33};
    tbl[5]  = '{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    tbl[6]  = '{OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1};
    tbl[7]  = '{OP_DIVU, 32'd1234, 32'd0, 32'hFFFF_FFFF, 1};
    tbl[8]  = '{OP_REMU, 32'd1234, 32'd0, 32'd1234, 1};
    tbl[9]  = '{OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1};
    tbl[10] = '{OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1};
    tbl[11] = '{OP_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 33};
    tbl[12] = '{OP_DIV, 32'd20, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 33};
    tbl[13] = '{OP_DIVU, 32'hFFFF_FFFF, 32'd10, 32'h1999_9999, 33};
    tbl[14] = '{OP_REMU, 32'hFFFF_FFFF, 32'd10, 32'd5, 33};

    for (int i = 0; i < NV; i++)
      run_op(tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].exp, tbl[i].lat);
    last = tbl[NV-1].exp;

    // abort at edge t+10
    @(negedge CLK);
    START = 1'b1; OP = OP_DIVU; X = 32'd100; Y = 32'd7;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (9) @(posedge CLK);
    @(negedge CLK);
    ABORT = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    ABORT = 1'b0;
    chk("abort_busy", 32'(BUSY), 32'd0);
    d0 = dones;
    repeat (40) @(negedge CLK);
    chk("abort_no_done", 32'(dones), 32'(d0));
    chk("abort_result_held", RESULT, last);

    // illegal op
    @(negedge CLK);
    START = 1'b1; OP = 5'd0; X = 32'd100; Y = 32'd7;
    @(negedge CLK);
    START = 1'b0;
    chk("badop_busy", 32'(BUSY), 32'd0);
    d0 = dones;
    repeat (5) @(negedge CLK);
    chk("badop_no_done", 32'(dones), 32'(d0));

    // START held high while busy
    d0 = dones;
    @(negedge CLK);
    START = 1'b1; OP = OP_DIVU; X = 32'd100; Y = 32'd7;
    @(posedge CLK);
    #1;
    e.exp = 32'd14; e.lat = 33; e.t0 = cyc;
    sb.push_back(e);
    repeat (33) @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    repeat (40) @(negedge CLK);
    chk("held_start_one_done", 32'(dones - d0), 32'd1);
    chk("held_start_drained", 32'(sb.size()), 32'd0);
    sb.delete();

    // reset at edge t+20
    @(negedge CLK);
    START = 1'b1; OP = OP_DIVU; X = 32'd100; Y = 32'd7;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (19) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_result", RESULT, 32'd0);
    RST = 1'b0;
    run_op(OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

    repeat (3) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
